// File: rtl/div_seq_pkg.sv
// Shared state encoding and handshake constants for the sequential divider.
// Imported by div_seq; the state enum is the one place the encoding is defined.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// signs fixed up in a final cycle; {remainder, quotient} held until start_i drops.
//
// Handshake: execute raises start_i with operands valid; they are sampled on the
// accepting edge. ready_o then rises once and stays high, with result_o stable,
// for as long as start_i stays high. Dropping start_i returns the block to idle
// on the next edge. annul_i aborts only an operation still iterating.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] LP_CNT_DONE = CNT_W'(WIDTH);

  div_state_e         r_state;
  div_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2*WIDTH:0]   r_dividend;
  logic [2*WIDTH:0]   w_dividend_nxt;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   w_divisor_nxt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   w_quot_nxt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               r_neg_q;
  logic               w_neg_q_nxt;
  logic               r_neg_r;
  logic               w_neg_r_nxt;
  logic [2*WIDTH-1:0] w_result_nxt;
  logic               w_ready_nxt;

  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_op1_abs;
  logic [WIDTH-1:0]   w_op2_abs;
  logic [WIDTH-1:0]   w_quot_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic               w_accept;

  // Only signed operands with the sign bit set are negated; DIVU passes through.
  assign w_op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  // Partial remainder plus the next dividend bit, less the divisor; MSB set means "restore".
  assign w_diff     = r_dividend[2*WIDTH:WIDTH] - {1'b0, r_divisor};
  assign w_quot_mag = r_dividend[WIDTH-1:0];
  assign w_rem_mag  = r_dividend[2*WIDTH:WIDTH+1];
  assign w_accept   = (start_i == DIV_START) && !annul_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_quot_nxt     = r_quot;
    w_rem_nxt      = r_rem;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_result_nxt   = '0;
    w_ready_nxt    = DIV_RESULT_NOT_READY;

    unique case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            w_state_nxt    = DIV_ON;
            w_cnt_nxt      = '0;
            w_dividend_nxt = {{WIDTH{1'b0}}, w_op1_abs, 1'b0};
            w_divisor_nxt  = w_op2_abs;
            w_neg_q_nxt    = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            w_neg_r_nxt    = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end

      DIV_BY_ZERO: begin
        w_state_nxt = DIV_END;
        w_quot_nxt  = '0;
        w_rem_nxt   = '0;
      end

      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else if (r_cnt != LP_CNT_DONE) begin
          if (w_diff[WIDTH]) begin
            w_dividend_nxt = {r_dividend[2*WIDTH-1:0], 1'b0};
          end else begin
            w_dividend_nxt = {w_diff[WIDTH-1:0], r_dividend[WIDTH-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = DIV_END;
          w_cnt_nxt   = '0;
          w_quot_nxt  = r_neg_q ? (~w_quot_mag + WIDTH'(1)) : w_quot_mag;
          w_rem_nxt   = r_neg_r ? (~w_rem_mag + WIDTH'(1)) : w_rem_mag;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_result_nxt = {r_rem, r_quot};
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end

      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      result_o   <= '0;
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_quot     <= w_quot_nxt;
      r_rem      <= w_rem_nxt;
      r_neg_q    <= w_neg_q_nxt;
      r_neg_r    <= w_neg_r_nxt;
      result_o   <= w_result_nxt;
      ready_o    <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: arithmetic reference model plus per-cycle compare of ready_o/result_o.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic        chk_en   = 1'b0;
  logic        m_ready  = 1'b0;
  logic [63:0] m_result = '0;
  logic [63:0] exp_q[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero; /0 gives 0.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = {32'd0, a} / {32'd0, b};
    ur = {32'd0, a} % {32'd0, b};
    return {ur[31:0], uq[31:0]};
  endfunction

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o", {63'd0, ready_o}, {63'd0, m_ready});
      check("result_o", result_o, m_result);
    end
  end

  // driver: pre_annul cycles of start+annul first, annul_k = edge index for a flush (0 = none)
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int annul_k, input int pre_annul);
    int  lat;
    int  last_k;
    bit  annulled;
    logic [63:0] discard;
    lat      = (b == 32'd0) ? 2 : 34;
    annulled = 1'b0;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = (pre_annul > 0);
    for (int p = 0; p < pre_annul; p++) begin
      @(posedge clk); #1;
      m_ready = 1'b0; m_result = '0;
      @(negedge clk);
    end
    annul_i = 1'b0;
    exp_q.push_back(model(sgn, a, b));
    last_k = (annul_k > 0) ? annul_k + 5 : lat + 1 + hold;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (annulled || k < lat + 1) begin
        m_ready = 1'b0; m_result = '0;
      end else if (k == lat + 1) begin
        m_result = exp_q.pop_front();
        m_ready  = 1'b1;
      end
      @(negedge clk);
      if (annul_k > 0) begin
        annul_i = (k + 1 == annul_k);
        if (k + 1 == annul_k) begin
          start_i  = 1'b0;
          annulled = 1'b1;
        end
      end else if ((b == 32'd0) ? (k >= 1) : (k >= lat)) begin
        annul_i = 1'($urandom_range(0, 1));
      end
    end
    if (annulled) begin
      discard = exp_q.pop_front();
    end else begin
      start_i = 1'b0;
      @(posedge clk); #1;
      m_ready = 1'b0; m_result = '0;
      @(negedge clk);
    end
    annul_i = 1'b0;
  endtask

  // async reset after 'edges' edges of DIVU 100/7, checked without any clock edge
  task automatic reset_mid(input int edges);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1; annul_i = 1'b0;
    repeat (edges) @(posedge clk);
    chk_en = 1'b0;
    #2;
    if (edges >= 35) begin
      check("pre_reset_ready", {63'd0, ready_o}, 64'd1);
      check("pre_reset_result", result_o, 64'h00000002_0000000E);
    end
    rst = 1'b1;
    #1;
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b0; m_result = '0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    rst = 1'b1;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    #12;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // hand-computed pins on the model
    check("model_divu_100_7", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    check("model_div_m7_2", model(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    check("model_div_7_m2", model(1'b1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
    check("model_div_ovf", model(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    check("model_divu_max_1", model(1'b0, 32'hFFFFFFFF, 32'd1), 64'h00000000_FFFFFFFF);
    check("model_div_9_3", model(1'b0, 32'd9, 32'd3), 64'h00000000_00000003);

    // directed
    run_div(1'b0, 32'd100, 32'd7, 3, 0, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1, 0, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0, 0);
    run_div(1'b0, 32'd5, 32'd0, 2, 0, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 0, 0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1, 0, 0);
    run_div(1'b0, 32'd100, 32'd7, 0, 11, 0);
    run_div(1'b0, 32'd9, 32'd3, 1, 0, 0);
    run_div(1'b0, 32'd9, 32'd3, 1, 0, 3);

    reset_mid(16);
    run_div(1'b0, 32'd100, 32'd7, 1, 0, 0);
    reset_mid(35);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1, 0, 0);

    // randomized
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run_div(sgn, a, b, $urandom_range(0, 3), 0, 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
